// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM state
// encoding and the default depth of the attached data memory.
package lsu_pkg;

  localparam int unsigned LSU_DEPTH = 201;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering for the load/store unit: pulls a byte/half/word out of a
// memory word with sign or zero extension, and merges store data into the
// selected lane of a word for read-modify-write stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, extend it for loads, splice it in for stores.
  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = word_i[{off_i[1], 4'b0000} +: 16];
    load_o   = word_i;
    merged_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o   = signed_i ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
        merged_o = word_i;
        merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o   = signed_i ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        merged_o = word_i;
        merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o   = word_i;
        merged_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-addressed data memory port.
// Accepts one CPU request at a time, converts the byte address to a word
// index, performs sub-word loads with extension and sub-word stores as
// read-modify-write, and returns one response pulse per request.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned
// half/word accesses are rejected with resp_err; otherwise the low address
// bits below the access size are ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH  = LSU_DEPTH,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       dataIn,
  input  logic [31:0]       dataOut
);

  lsu_state_e        state_q;
  logic              resp_valid_q, resp_err_q, memRead_q, memWrite_q;
  logic [31:0]       resp_rdata_q, dataIn_q;
  logic [ADDR_W-1:0] address_q;
  logic              write_q, signed_q;
  logic [1:0]        size_q, off_q;
  logic [31:0]       wdata_q;

  logic [ADDR_W-1:0] word_idx;
  logic              acc_err;
  logic [1:0]        acc_off_d;
  logic [31:0]       load_val, merged_val;

  assign word_idx = req_addr >> 2;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  // Misaligned half/word accesses are trapped; the raw offset is kept.
  always_comb begin
    misalign  = ((req_size == SZ_HALF) && req_addr[0]) ||
                ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    acc_err   = (req_size == SZ_RSVD) || (word_idx >= ADDR_W'(DEPTH)) || misalign;
    acc_off_d = req_addr[1:0];
  end
`else
  // Offset bits below the access size are dropped so the access is aligned.
  always_comb begin
    acc_err = (req_size == SZ_RSVD) || (word_idx >= ADDR_W'(DEPTH));
    case (req_size)
      SZ_HALF: acc_off_d = {req_addr[1], 1'b0};
      SZ_WORD: acc_off_d = 2'b00;
      default: acc_off_d = req_addr[1:0];
    endcase
  end
`endif

  lsu_lane_align u_align (
    .word_i   (dataOut),
    .size_i   (size_q),
    .off_i    (off_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .load_o   (load_val),
    .merged_o (merged_val)
  );

  // Request FSM with registered memory-port and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      memRead_q    <= 1'b0;
      memWrite_q   <= 1'b0;
      address_q    <= '0;
      dataIn_q     <= 32'h0;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= SZ_BYTE;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            size_q   <= req_size;
            off_q    <= acc_off_d;
            wdata_q  <= req_wdata;
            if (acc_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else if (req_write && (req_size == SZ_WORD)) begin
              state_q    <= WRITE;
              memWrite_q <= 1'b1;
              address_q  <= word_idx;
              dataIn_q   <= req_wdata;
            end else begin
              state_q   <= READ;
              memRead_q <= 1'b1;
              address_q <= word_idx;
            end
          end
        end
        READ: begin
          memRead_q <= 1'b0;
          if (write_q) begin
            state_q    <= WRITE;
            memWrite_q <= 1'b1;
            dataIn_q   <= merged_val;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_val;
          end
        end
        WRITE: begin
          memWrite_q   <= 1'b0;
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign memRead    = memRead_q;
  assign memWrite   = memWrite_q;
  assign address    = address_q;
  assign dataIn     = dataIn_q;

endmodule
